chipscope_vio_to_chip: RTL and testbench
========================================

CHIPSCOPE_VIO_TO_CHIP -- requirements
Module: chipscope_vio_to_chip

Interface
- REQ-001: Parameter WIDTH, default 256, SYNC_OUT width in bits; SHALL be a multiple of 16 in range 16..256.
- REQ-002: CLK  input  1  single clock; all state SHALL change only on rising CLK edges, except on reset.
- REQ-003: RST  input  1  reset, asynchronous, active-high.
- REQ-004: CONTROL  input  36  host control bus, treated as synchronous to CLK.
  - [15:0] DATA halfword.
  - [19:16] IDX halfword index.
  - [21:20] OP: 00 idle, 01 write, 10 commit, 11 clear.
  - [35:22] reserved, SHALL be ignored.
- REQ-005: SYNC_OUT  output  WIDTH  committed value driven into the design.
- REQ-006: UPDATE  output  1  one-cycle pulse marking a SYNC_OUT load.

Function
- REQ-007: Block SHALL hold an internal WIDTH-bit shadow register plus the WIDTH-bit SYNC_OUT register.
- REQ-008: "Effective CONTROL" SHALL be CONTROL itself, or the synchronized copy when REQ-020 applies. All OP decoding uses effective CONTROL sampled at the rising CLK edge.
- REQ-009: OP=01 with IDX < WIDTH/16
  - SHALL load shadow[16*IDX+15:16*IDX] with DATA at that edge.
  - All other shadow bits unchanged.
- REQ-010: OP=01 with IDX >= WIDTH/16 SHALL leave the shadow unchanged; no error indication.
- REQ-011: OP=10 SHALL load SYNC_OUT with the shadow value as it stood before that edge. Shadow is unchanged.
- REQ-012: OP=11 SHALL clear the shadow to zero. SYNC_OUT is unchanged.
- REQ-013: OP=00 SHALL change no state.
- REQ-014: UPDATE SHALL be registered: high for the cycle following each edge that sampled OP=10, low otherwise.
- REQ-015: OP held for several cycles SHALL repeat the operation every cycle (all ops idempotent).
  - A held commit gives UPDATE high for every such cycle.
- REQ-016: Latency without REQ-020
  - A write at edge N is visible to a commit sampled at edge N+1.
  - SYNC_OUT and UPDATE change at the commit edge itself.
- REQ-017: SYNC_OUT SHALL change only on commit or reset. It never exposes a partially written shadow.

Reset
- REQ-018: RST high SHALL immediately clear, independent of CLK:
  - the shadow;
  - SYNC_OUT;
  - UPDATE;
  - any synchronizer stages.
- REQ-019: While RST is high, CONTROL SHALL be ignored. Normal decoding resumes at the first rising edge after RST falls.
  - Reset asserted mid-sequence discards all partially written shadow data.

Configuration
- REQ-020: Macro CHIPSCOPE_VIO_CDC_EN
  - When defined, CONTROL SHALL pass through a two-stage register synchronizer before decoding. This adds exactly 2 cycles of latency to every operation and UPDATE.
  - When undefined, CONTROL SHALL be decoded directly with no added latency.

Verification
- REQ-021: Reset: assert RST with arbitrary CONTROL -> SYNC_OUT=0 and UPDATE=0 immediately, with no clock edge needed.
- REQ-022: Write, then commit, WIDTH=256
  - Stimulus: write IDX 0..15 with DATA 16'h1000+IDX, then one commit cycle.
  - Expected: SYNC_OUT[15:0]=16'h1000 and SYNC_OUT[255:240]=16'h100F; UPDATE high for exactly one cycle.
- REQ-023: Atomicity
  - Stimulus: after REQ-022, write IDX 3 with 16'hBEEF, no commit.
  - Expected: SYNC_OUT unchanged.
  - Stimulus: then commit.
  - Expected: SYNC_OUT[63:48]=16'hBEEF and all other halfwords retained.
- REQ-024: Clear and out-of-range write
  - Stimulus: WIDTH=64; clear, write IDX 4 with 16'hFFFF, commit.
  - Expected: SYNC_OUT=64'h0; UPDATE pulses.
- REQ-025: Back-to-back and reserved bits
  - Stimulus: write at edge N with CONTROL[35:22] all ones, commit at edge N+1.
  - Expected: new halfword present in SYNC_OUT after edge N+1; reserved bits have no effect.
- REQ-026: With CHIPSCOPE_VIO_CDC_EN defined, repeat REQ-022 -> SYNC_OUT and UPDATE change exactly 2 cycles later than without the macro.

Source files
------------

// File: rtl/chipscope_vio_to_chip_if.sv
// Host-side VIO bundle: 36-bit control word in, committed value and load pulse out.
interface chipscope_vio_to_chip_if #(
  parameter int WIDTH = 256
);
  logic [35:0]      CONTROL;
  logic [WIDTH-1:0] SYNC_OUT;
  logic             UPDATE;

  modport master (output CONTROL, input SYNC_OUT, input UPDATE);
  modport slave  (input CONTROL, output SYNC_OUT, output UPDATE);
endinterface

// File: rtl/chipscope_vio_to_chip.sv
// VIO shadow/commit register: halfword writes build a shadow, a commit loads it atomically onto SYNC_OUT.
// Optional macro CHIPSCOPE_VIO_CDC_EN inserts a two-stage synchronizer on CONTROL before decoding.
module chipscope_vio_to_chip #(
  parameter int WIDTH = 256
) (
  input logic                     CLK,
  input logic                     RST,
  chipscope_vio_to_chip_if.slave  vio
);

  localparam int NHW = WIDTH / 16;

  localparam logic [1:0] OP_IDLE   = 2'b00;
  localparam logic [1:0] OP_WR     = 2'b01;
  localparam logic [1:0] OP_COMMIT = 2'b10;
  localparam logic [1:0] OP_CLR    = 2'b11;

  if ((WIDTH % 16) != 0 || WIDTH < 16 || WIDTH > 256) begin : g_bad_width
    $error("chipscope_vio_to_chip: WIDTH must be a multiple of 16 in 16..256");
  end

  logic [21:0] ctrl_eff;
  logic        unused_rsvd;

  // Reserved control bits [35:22] are deliberately dropped before any staging.
  assign unused_rsvd = ^vio.CONTROL[35:22];

`ifdef CHIPSCOPE_VIO_CDC_EN
  logic [21:0] sync1_q, sync1_d;
  logic [21:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = vio.CONTROL[21:0];
    sync2_d = sync1_q;
  end

  // Synchronizer stages reset to OP_IDLE so nothing decodes right after reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign ctrl_eff = sync2_q;
`else
  assign ctrl_eff = vio.CONTROL[21:0];
`endif

  logic [1:0]       op;
  logic [3:0]       idx;
  logic [15:0]      data;

  assign data = ctrl_eff[15:0];
  assign idx  = ctrl_eff[19:16];
  assign op   = ctrl_eff[21:20];

  logic [WIDTH-1:0] shadow_q,   shadow_d;
  logic [WIDTH-1:0] sync_out_q, sync_out_d;
  logic             update_q,   update_d;

  // Commit copies the pre-edge shadow, so a write and a commit never mix in one load.
  always_comb begin
    shadow_d   = shadow_q;
    sync_out_d = sync_out_q;
    update_d   = 1'b0;
    unique case (op)
      OP_IDLE: ;
      OP_WR: begin
        for (int h = 0; h < NHW; h++) begin
          if (int'(idx) == h) shadow_d[16*h +: 16] = data;
        end
      end
      OP_COMMIT: begin
        sync_out_d = shadow_q;
        update_d   = 1'b1;
      end
      OP_CLR: shadow_d = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shadow_q   <= '0;
      sync_out_q <= '0;
      update_q   <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      sync_out_q <= sync_out_d;
      update_q   <= update_d;
    end
  end

  assign vio.SYNC_OUT = sync_out_q;
  assign vio.UPDATE   = update_q;

endmodule

// File: tb/tb_chipscope_vio_to_chip.sv
// Directed bench for chipscope_vio_to_chip: a 256-bit and a 64-bit instance share one clock.
module tb_chipscope_vio_to_chip;

`ifdef CHIPSCOPE_VIO_CDC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  localparam logic [1:0] OP_IDLE   = 2'b00;
  localparam logic [1:0] OP_WR     = 2'b01;
  localparam logic [1:0] OP_COMMIT = 2'b10;
  localparam logic [1:0] OP_CLR    = 2'b11;

  logic CLK;
  logic RST;
  int   n_cmp;
  int   n_mis;

  chipscope_vio_to_chip_if #(.WIDTH(256)) ifa ();
  chipscope_vio_to_chip_if #(.WIDTH(64))  ifb ();

  chipscope_vio_to_chip #(.WIDTH(256)) dut_a (.CLK(CLK), .RST(RST), .vio(ifa.slave));
  chipscope_vio_to_chip #(.WIDTH(64))  dut_b (.CLK(CLK), .RST(RST), .vio(ifb.slave));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] mk(input logic [1:0] op, input int idx,
                                     input logic [15:0] d, input logic [13:0] r);
    return {r, op, idx[3:0], d};
  endfunction

  function automatic logic upd(input bit sel);
    return sel ? ifb.UPDATE : ifa.UPDATE;
  endfunction

  task automatic apply(input bit sel, input logic [35:0] c);
    if (sel) ifb.CONTROL = c;
    else     ifa.CONTROL = c;
    @(negedge CLK);
  endtask

  // Called at the negedge right after the commit cycle; UPDATE must rise exactly LAT cycles later for one cycle.
  task automatic pulse_chk(input bit sel, input string tag);
    for (int k = 0; k <= LAT; k++) begin
      if (sel) ifb.CONTROL = mk(OP_IDLE, 0, 16'h0, 14'h0);
      else     ifa.CONTROL = mk(OP_IDLE, 0, 16'h0, 14'h0);
      chk({tag, "_upd"}, 256'(upd(sel)), 256'(k == LAT));
      @(negedge CLK);
    end
    chk({tag, "_upd_end"}, 256'(upd(sel)), 256'(0));
  endtask

  initial begin
    int cnt;
    n_cmp = 0;
    n_mis = 0;
    RST = 1'b1;
    ifa.CONTROL = 36'hF_FFFF_FFFF;
    ifb.CONTROL = 36'hF_FFFF_FFFF;
    #1;
    chk("rst0_a_out", ifa.SYNC_OUT, '0);
    chk("rst0_a_upd", 256'(ifa.UPDATE), '0);
    chk("rst0_b_out", 256'(ifb.SYNC_OUT), '0);
    repeat (2) @(negedge CLK);
    chk("rst_held_a_upd", 256'(ifa.UPDATE), '0);
    RST = 1'b0;
    ifa.CONTROL = mk(OP_IDLE, 0, 16'h0, 14'h0);
    ifb.CONTROL = mk(OP_IDLE, 0, 16'h0, 14'h0);
    @(negedge CLK);

    // Fill all 16 halfwords, then commit once.
    for (int i = 0; i < 16; i++) apply(0, mk(OP_WR, i, 16'(16'h1000 + i), 14'h0));
    apply(0, mk(OP_COMMIT, 0, 16'h0, 14'h0));
    pulse_chk(0, "fill");
    chk("fill_hw0",  256'(ifa.SYNC_OUT[15:0]),    256'(16'h1000));
    chk("fill_hw15", 256'(ifa.SYNC_OUT[255:240]), 256'(16'h100F));
    chk("fill_hw7",  256'(ifa.SYNC_OUT[127:112]), 256'(16'h1007));

    // Uncommitted write stays invisible until the next commit.
    apply(0, mk(OP_WR, 3, 16'hBEEF, 14'h0));
    repeat (LAT + 2) apply(0, mk(OP_IDLE, 0, 16'h0, 14'h0));
    chk("atom_hold_hw3", 256'(ifa.SYNC_OUT[63:48]), 256'(16'h1003));
    chk("atom_hold_upd", 256'(ifa.UPDATE), '0);
    apply(0, mk(OP_COMMIT, 0, 16'h0, 14'h0));
    pulse_chk(0, "atom");
    chk("atom_hw3",  256'(ifa.SYNC_OUT[63:48]),   256'(16'hBEEF));
    chk("atom_hw2",  256'(ifa.SYNC_OUT[47:32]),   256'(16'h1002));
    chk("atom_hw15", 256'(ifa.SYNC_OUT[255:240]), 256'(16'h100F));

    // Back-to-back write/commit with reserved bits set.
    apply(0, mk(OP_WR, 5, 16'hA5A5, 14'h3FFF));
    apply(0, mk(OP_COMMIT, 0, 16'h0, 14'h3FFF));
    pulse_chk(0, "b2b");
    chk("b2b_hw5", 256'(ifa.SYNC_OUT[95:80]), 256'(16'hA5A5));
    chk("b2b_hw3", 256'(ifa.SYNC_OUT[63:48]), 256'(16'hBEEF));
    apply(0, mk(OP_IDLE, 6, 16'h7777, 14'h3FFF));
    apply(0, mk(OP_COMMIT, 0, 16'h0, 14'h0));
    pulse_chk(0, "rsvd_idle");
    chk("rsvd_idle_hw6", 256'(ifa.SYNC_OUT[111:96]), 256'(16'h1006));

    // 64-bit instance: top halfword, clear, and out-of-range index.
    apply(1, mk(OP_WR, 0, 16'h1234, 14'h0));
    apply(1, mk(OP_WR, 3, 16'hCAFE, 14'h0));
    apply(1, mk(OP_COMMIT, 0, 16'h0, 14'h0));
    pulse_chk(1, "w64");
    chk("w64_val", 256'(ifb.SYNC_OUT), 256'(64'hCAFE_0000_0000_1234));
    apply(1, mk(OP_CLR, 0, 16'h0, 14'h0));
    apply(1, mk(OP_WR, 4, 16'hFFFF, 14'h0));
    repeat (LAT + 2) apply(1, mk(OP_IDLE, 0, 16'h0, 14'h0));
    chk("clr_hold", 256'(ifb.SYNC_OUT), 256'(64'hCAFE_0000_0000_1234));
    apply(1, mk(OP_COMMIT, 0, 16'h0, 14'h0));
    pulse_chk(1, "clr");
    chk("clr_val", 256'(ifb.SYNC_OUT), 256'(64'h0));

    // Held commit: one UPDATE cycle per commit cycle.
    apply(1, mk(OP_WR, 1, 16'h5A5A, 14'h0));
    apply(1, mk(OP_IDLE, 0, 16'h0, 14'h0));
    cnt = 0;
    for (int k = 0; k < LAT + 6; k++) begin
      ifb.CONTROL = (k < 3) ? mk(OP_COMMIT, 0, 16'h0, 14'h0) : mk(OP_IDLE, 0, 16'h0, 14'h0);
      @(negedge CLK);
      if (ifb.UPDATE) cnt++;
    end
    chk("held_cnt", 256'(cnt), 256'(3));
    chk("held_val", 256'(ifb.SYNC_OUT), 256'(64'h0000_0000_5A5A_0000));

    // Asynchronous reset while UPDATE is high, then check the shadow was wiped.
    repeat (LAT + 2) apply(0, mk(OP_COMMIT, 0, 16'h0, 14'h0));
    chk("pre_rst_upd", 256'(ifa.UPDATE), 256'(1));
    #2 RST = 1'b1;
    #1;
    chk("arst_a_out", ifa.SYNC_OUT, '0);
    chk("arst_a_upd", 256'(ifa.UPDATE), '0);
    chk("arst_b_out", 256'(ifb.SYNC_OUT), '0);
    repeat (2) @(negedge CLK);
    chk("arst_held_upd", 256'(ifa.UPDATE), '0);
    RST = 1'b0;
    repeat (LAT + 2) apply(0, mk(OP_IDLE, 0, 16'h0, 14'h0));
    apply(0, mk(OP_COMMIT, 0, 16'h0, 14'h0));
    pulse_chk(0, "post_rst");
    chk("post_rst_val", ifa.SYNC_OUT, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
